// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encoding and default limits for the memory arbiter
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        RESP_IF = 3'd3,
        RESP_DM = 3'd4
    } arb_state_t;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT    = 255;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one memory port with starvation guard and timeout
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        err
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int BW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] busy_cnt;
    logic          grant_if;
    logic          grant_dm;
    logic          starved;
    logic          timed_out;

    // Data normally wins; a fetch that has watched STARVE_MAX data grants goes first.
    always_comb begin
        starved   = (starve_cnt == SW'(STARVE_MAX));
        grant_if  = if_req && (!dm_req || starved);
        grant_dm  = dm_req && !grant_if;
        timed_out = (busy_cnt == BW'(TIMEOUT));
    end

    assign mem_req  = (state == BUSY_IF) || (state == BUSY_DM);
    assign if_ready = (state == RESP_IF);
    assign dm_ready = (state == RESP_DM);
    assign stall    = (if_req & ~if_ready) | (dm_req & ~dm_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            busy_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        state      <= BUSY_IF;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        busy_cnt   <= '0;
                        starve_cnt <= '0;
                    end else if (grant_dm) begin
                        state     <= BUSY_DM;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        busy_cnt  <= '0;
                        if (if_req && !starved)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // A completion in the timeout cycle still counts as a normal completion.
                    if (mem_ready) begin
                        state <= (state == BUSY_IF) ? RESP_IF : RESP_DM;
                        if (state == BUSY_IF)
                            if_rdata <= mem_rdata;
                        else if (!mem_we)
                            dm_rdata <= mem_rdata;
                    end else if (timed_out) begin
                        state <= (state == BUSY_IF) ? RESP_IF : RESP_DM;
                        err   <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                RESP_IF, RESP_DM: state <= IDLE;
                default:          state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): STARVE_MAX, 4, consecutive data grants allowed while a fetch request waits.
REQ-002 SHALL have parameter TIMEOUT, 255, maximum BUSY cycles before a memory access is aborted.
REQ-003 SHALL have ports: clk input 1 (the single clock); reset input 1 (synchronous, active-low: reset==0 resets at the clk rising edge).
REQ-004 SHALL have ports: if_req input 1 (fetch request); if_addr input 32; if_rdata output 32; if_ready output 1 (fetch done pulse).
REQ-005 SHALL have ports: dm_req input 1 (data request); dm_we input 1; dm_addr input 32; dm_wdata input 32; dm_rdata output 32; dm_ready output 1 (data done pulse).
REQ-006 SHALL have ports: mem_req output 1; mem_we output 1; mem_addr output 32; mem_wdata output 32; mem_rdata input 32; mem_ready input 1.
REQ-007 SHALL have ports: stall output 1 (pipeline stall); err output 1 (timeout pulse).

Function
REQ-008 SHALL implement states IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM.
REQ-009 Requesters SHALL hold req and operands stable until their ready pulse; the arbiter samples requests only in IDLE.
REQ-010 IDLE with dm_req=1 SHALL go to BUSY_DM, except when if_req=1 and starve_cnt==STARVE_MAX, which SHALL go to BUSY_IF.
REQ-011 IDLE with only if_req=1 SHALL go to BUSY_IF; with no request SHALL stay IDLE.
REQ-012 On the IDLE->BUSY edge SHALL register mem_addr, mem_we (0 for fetch), mem_wdata from the winner.
REQ-013 mem_req SHALL be 1 exactly in BUSY_IF/BUSY_DM.
REQ-014 mem_ready=1 in BUSY_x SHALL capture mem_rdata into x_rdata (data reads only; writes leave dm_rdata unchanged) and go to RESP_x.
REQ-015 x_ready SHALL be 1 exactly in RESP_x (one cycle); RESP_x SHALL always go to IDLE.
REQ-016 Latency: request visible in IDLE at cycle 0 with mem_ready at cycle k SHALL produce x_ready at cycle k+1; minimum k=1, giving 2 cycles.
REQ-017 mem_ready outside BUSY states SHALL be ignored.
REQ-018 starve_cnt SHALL increment (saturating at STARVE_MAX) on each DM grant while if_req=1, and SHALL clear on each IF grant.
REQ-019 busy_cnt SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready; width $clog2(TIMEOUT+1).
REQ-020 busy_cnt==TIMEOUT without mem_ready SHALL go to RESP_x, pulse err=1 with x_ready=1, and leave x_rdata unchanged.
REQ-021 mem_ready in the same cycle as timeout SHALL win: normal completion with err=0.
REQ-022 stall SHALL be combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).

Reset
REQ-023 reset==0 SHALL force state IDLE, starve_cnt=0, busy_cnt=0 on the next edge, including mid-access.
REQ-024 Reset values SHALL be: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, err=0.
REQ-025 An access aborted by reset SHALL produce no ready pulse.

Structure
REQ-026 mips_pkg SHALL hold the arb_state_t enum and the default constants for STARVE_MAX and TIMEOUT.
REQ-027 The block SHALL be a single module with no sub-modules; counters and the FSM are inline.

Verification
REQ-028 Fetch read: if_req=1 with if_addr=0x40, memory returning 0x8C010004 after 1 cycle -> if_ready at cycle 2, if_rdata=0x8C010004, stall=1 in cycles 0-1.
REQ-029 Simultaneous requests: if_req and dm_req (dm_we=1, addr 0x100, wdata 0xDEADBEEF) -> DM granted first, mem_we=1; IF granted after the RESP_DM->IDLE cycle.
REQ-030 Starvation: dm_req re-asserted continuously with if_req held -> 4 DM grants, then IF granted on the 5th arbitration, starve_cnt back to 0.
REQ-031 Timeout: mem_ready never asserted -> after 255 BUSY cycles, RESP with err=1 and ready=1; mem_ready at exactly cycle 255 -> err=0.
REQ-032 Reset mid-access: reset=0 during BUSY_DM -> next cycle IDLE, mem_req=0, no dm_ready pulse, all outputs at reset values.
